// File: rtl/piece_mover.sv
// rtl/piece_mover.sv - active-piece engine: spawn load, gravity, lateral moves, hard drop, landing
//
// Ports:
//   clka        clock, all logic on posedge
//   restart     synchronous active-high reset
//   state       game phase; 1 = MOVE
//   board_in    board from clear/redraw (landed cells plus spawned piece)
//   curr_piece  piece id: 00 single, 01 bar, 10 square, 11 L
//   btn_left    move-left level (rising edge acts)
//   btn_right   move-right level (rising edge acts)
//   btn_drop    hard-drop level (rising edge acts)
//   board_out   registered background | piece mask
//   landed      one-cycle pulse on the first LANDED cycle
//   moving      high while falling or dropping
module piece_mover #(
    parameter int ROWS     = 8,
    parameter int COLS     = 4,
    parameter int TICK_DIV = 4
) (
    input  logic                   clka,
    input  logic                   restart,
    input  logic [2:0]             state,
    input  logic [ROWS*COLS-1:0]   board_in,
    input  logic [1:0]             curr_piece,
    input  logic                   btn_left,
    input  logic                   btn_right,
    input  logic                   btn_drop,
    output logic [ROWS*COLS-1:0]   board_out,
    output logic                   landed,
    output logic                   moving
);
    localparam int BW = ROWS * COLS;
    localparam int CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

    function automatic logic [BW-1:0] col_mask(input int c);
        logic [BW-1:0] m;
        m = '0;
        for (int r = 0; r < ROWS; r++) m[r*COLS+c] = 1'b1;
        return m;
    endfunction

    function automatic logic [BW-1:0] bottom_row();
        logic [BW-1:0] m;
        m = '0;
        for (int c = 0; c < COLS; c++) m[(ROWS-1)*COLS+c] = 1'b1;
        return m;
    endfunction

    localparam logic [BW-1:0] COL_L = col_mask(0);
    localparam logic [BW-1:0] COL_R = col_mask(COLS-1);
    localparam logic [BW-1:0] ROW_B = bottom_row();

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_FALL, S_DROP, S_LANDED
    } fsm_t;

    fsm_t          fsm_q, fsm_d;
    logic [BW-1:0] mask_q, mask_d;
    logic [BW-1:0] bg_q, bg_d;
    logic [BW-1:0] board_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          pend_q, pend_d;
    logic          landed_q;
    logic          left_q, right_q, drop_q;

    logic [BW-1:0] spawn;
    logic          in_move, tick, do_down, down_blocked;
    logic          left_e, right_e, drop_e, can_left, can_right;

    always_comb begin
        spawn = '0;
        case (curr_piece)
            2'b00: spawn[1] = 1'b1;
            2'b01: begin spawn[1] = 1'b1; spawn[COLS+1] = 1'b1; end
            2'b10: begin
                spawn[1] = 1'b1; spawn[2] = 1'b1;
                spawn[COLS+1] = 1'b1; spawn[COLS+2] = 1'b1;
            end
            default: begin
                spawn[1] = 1'b1; spawn[COLS+1] = 1'b1; spawn[COLS+2] = 1'b1;
            end
        endcase
    end

    assign in_move      = (state == 3'd1);
    assign tick         = (cnt_q == CW'(TICK_DIV-1));
    assign left_e       = btn_left  & ~left_q;
    assign right_e      = btn_right & ~right_q;
    assign drop_e       = btn_drop  & ~drop_q;
    // Column guards stop a shift from wrapping into the neighbouring row.
    assign can_left     = ~|(mask_q & COL_L) & ~|((mask_q >> 1) & bg_q);
    assign can_right    = ~|(mask_q & COL_R) & ~|((mask_q << 1) & bg_q);
    assign down_blocked = |(mask_q & ROW_B) | |((mask_q << COLS) & bg_q);

    always_comb begin
        fsm_d   = fsm_q;
        mask_d  = mask_q;
        bg_d    = bg_q;
        cnt_d   = cnt_q;
        pend_d  = pend_q;
        do_down = 1'b0;
        case (fsm_q)
            S_IDLE: if (in_move) fsm_d = S_LOAD;
            S_LOAD: begin
                if (!in_move) begin
                    fsm_d = S_IDLE;
                end else begin
                    mask_d = spawn;
                    bg_d   = board_in & ~spawn;
                    cnt_d  = '0;
                    pend_d = 1'b0;
                    fsm_d  = S_FALL;
                end
            end
            S_FALL: begin
                if (!in_move) begin
                    fsm_d = S_IDLE;
                end else begin
                    cnt_d = tick ? '0 : cnt_q + 1'b1;
                    if (drop_e) begin
                        fsm_d = S_DROP;
                    end else if ((left_e ^ right_e) && (left_e ? can_left : can_right)) begin
                        mask_d = left_e ? (mask_q >> 1) : (mask_q << 1);
                        // Gravity colliding with a lateral move is deferred one cycle.
                        if (tick) pend_d = 1'b1;
                    end else if (tick || pend_q) begin
                        pend_d  = 1'b0;
                        do_down = 1'b1;
                    end
                end
            end
            S_DROP: begin
                if (!in_move) fsm_d = S_IDLE;
                else          do_down = 1'b1;
            end
            S_LANDED: if (!in_move) fsm_d = S_IDLE;
            default:  fsm_d = S_IDLE;
        endcase
        if (do_down) begin
            if (down_blocked) begin
                bg_d   = bg_q | mask_q;
                mask_d = '0;
                fsm_d  = S_LANDED;
            end else begin
                mask_d = mask_q << COLS;
            end
        end
    end

    always_ff @(posedge clka) begin
        if (restart) begin
            fsm_q    <= S_IDLE;
            mask_q   <= '0;
            bg_q     <= '0;
            board_q  <= '0;
            cnt_q    <= '0;
            pend_q   <= 1'b0;
            landed_q <= 1'b0;
            left_q   <= 1'b0;
            right_q  <= 1'b0;
            drop_q   <= 1'b0;
        end else begin
            fsm_q    <= fsm_d;
            mask_q   <= mask_d;
            bg_q     <= bg_d;
            board_q  <= bg_d | mask_d;
            cnt_q    <= cnt_d;
            pend_q   <= pend_d;
            landed_q <= (fsm_d == S_LANDED) && (fsm_q != S_LANDED);
            left_q   <= btn_left;
            right_q  <= btn_right;
            drop_q   <= btn_drop;
        end
    end

    assign board_out = board_q;
    assign landed    = landed_q;
    assign moving    = (fsm_q == S_FALL) || (fsm_q == S_DROP);
endmodule
